// File: rtl/message_bus_arbiter.sv
// Round-robin arbiter sharing one message bus among NODES senders, with a
// single-entry buffer slot that delivers to the destination's receive port.

module mba_lane #(
    parameter int NODES = 4,
    parameter int ID_W  = 2,
    parameter int IDX   = 0
) (
    input  logic [31:0]     dst,
    input  logic            grant,
    input  logic [ID_W-1:0] win,
    input  logic            slot_valid,
    input  logic [ID_W-1:0] slot_dst,
    output logic            dst_ok,
    output logic            ack,
    output logic            rcv_val
);
    // Full 32-bit compare so garbage in the upper bits is never aliased onto a node.
    assign dst_ok  = dst < 32'(NODES);
    assign ack     = grant && (win == ID_W'(IDX));
    assign rcv_val = slot_valid && (slot_dst == ID_W'(IDX));
endmodule

module message_bus_arbiter #(
    parameter int NODES  = 4,
    parameter int ID_W   = $clog2(NODES),
    parameter int DROP_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [NODES-1:0]    snd_val_i,
    output logic [NODES-1:0]    snd_ack_o,
    input  logic [NODES*32-1:0] snd_dst_i,
    input  logic [NODES*32-1:0] snd_tag_i,
    input  logic [NODES*64-1:0] snd_msg_i,
    output logic [NODES-1:0]    rcv_val_o,
    input  logic [NODES-1:0]    rcv_rdy_i,
    output logic [31:0]         rcv_src_o,
    output logic [31:0]         rcv_tag_o,
    output logic [63:0]         rcv_msg_o,
    output logic                busy_o,
    output logic [DROP_W-1:0]   drop_count_o
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state;
    logic [ID_W-1:0]     slot_src, slot_dst, rr_ptr;
    logic [31:0]         slot_tag;
    logic [63:0]         slot_msg;
    logic [DROP_W-1:0]   drop_cnt;

    logic [NODES-1:0][31:0]   dst_a, tag_a;
    logic [NODES-1:0][63:0]   msg_a;
    logic [NODES-1:0][ID_W-1:0] scan_idx;
    logic [NODES-1:0]         dst_ok;
    logic                     slot_valid, deliver, free, grant, req_any, win_ok;
    logic [ID_W-1:0]          win, win_next;

    assign dst_a = snd_dst_i;
    assign tag_a = snd_tag_i;
    assign msg_a = snd_msg_i;

    assign slot_valid = (state == FULL);
    assign deliver    = slot_valid && rcv_rdy_i[slot_dst];
    assign free       = !slot_valid || deliver;

    // scan_idx[k] is the node examined k-th, starting at the round-robin pointer.
    for (genvar k = 0; k < NODES; k++) begin : g_scan
        assign scan_idx[k] = ID_W'((int'(rr_ptr) + k) % NODES);
    end

    always_comb begin
        req_any = |snd_val_i;
        win     = '0;
        for (int k = NODES - 1; k >= 0; k--)
            if (snd_val_i[scan_idx[k]]) win = scan_idx[k];
    end

    assign grant    = rst_n && free && !flush && req_any;
    assign win_ok   = dst_ok[win];
    assign win_next = (win == ID_W'(NODES - 1)) ? '0 : win + 1'b1;

    for (genvar n = 0; n < NODES; n++) begin : g_lane
        mba_lane #(.NODES(NODES), .ID_W(ID_W), .IDX(n)) u_lane (
            .dst        (dst_a[n]),
            .grant      (grant),
            .win        (win),
            .slot_valid (slot_valid),
            .slot_dst   (slot_dst),
            .dst_ok     (dst_ok[n]),
            .ack        (snd_ack_o[n]),
            .rcv_val    (rcv_val_o[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            slot_src <= '0;
            slot_dst <= '0;
            slot_tag <= '0;
            slot_msg <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (grant) begin
            rr_ptr <= win_next;
            if (win_ok) begin
                state    <= FULL;
                slot_src <= win;
                slot_dst <= dst_a[win][ID_W-1:0];
                slot_tag <= tag_a[win];
                slot_msg <= msg_a[win];
            end else begin
                // A grant implies the slot is free this cycle, so a drop leaves it empty.
                state <= EMPTY;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (deliver) begin
            state <= EMPTY;
        end
    end

    assign rcv_src_o    = {{(32 - ID_W){1'b0}}, slot_src};
    assign rcv_tag_o    = slot_tag;
    assign rcv_msg_o    = slot_msg;
    assign busy_o       = slot_valid;
    assign drop_count_o = drop_cnt;
endmodule

// File: tb/tb_message_bus_arbiter.sv
// Directed bench for message_bus_arbiter: per-cycle model compare plus
// hand-computed expectations for each scenario.

module tb_message_bus_arbiter;
    localparam int NODES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [NODES-1:0] val = '0, rdy = '0;
    logic [NODES-1:0][31:0] dst = '0, tag = '0;
    logic [NODES-1:0][63:0] msg = '0;

    logic [NODES-1:0] ack, rcv_val, ack_s, rcv_val_s;
    logic [31:0] src, rtag, src_s, rtag_s;
    logic [63:0] rmsg, rmsg_s;
    logic busy, busy_s;
    logic [15:0] drops;
    logic [2:0]  drops_s;

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    message_bus_arbiter #(.NODES(NODES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .snd_val_i(val), .snd_ack_o(ack), .snd_dst_i(dst), .snd_tag_i(tag), .snd_msg_i(msg),
        .rcv_val_o(rcv_val), .rcv_rdy_i(rdy), .rcv_src_o(src), .rcv_tag_o(rtag), .rcv_msg_o(rmsg),
        .busy_o(busy), .drop_count_o(drops)
    );

    // Narrow drop counter instance to reach saturation in a few cycles.
    message_bus_arbiter #(.NODES(NODES), .DROP_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .snd_val_i(val), .snd_ack_o(ack_s), .snd_dst_i(dst), .snd_tag_i(tag), .snd_msg_i(msg),
        .rcv_val_o(rcv_val_s), .rcv_rdy_i(rdy), .rcv_src_o(src_s), .rcv_tag_o(rtag_s), .rcv_msg_o(rmsg_s),
        .busy_o(busy_s), .drop_count_o(drops_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the slot is either holding a message or not; senders are scanned in
    // circular order from the node after the last one accepted.
    bit m_valid, n_valid;
    int m_src, m_dst, m_ptr, m_drops, n_src, n_dst, n_ptr, n_drops;
    logic [31:0] m_tag, n_tag;
    logic [63:0] m_msg, n_msg;
    bit any;
    int w, nn;
    logic [NODES-1:0] e_ack, e_val;

    always @(negedge clk) begin
        any = 0; w = 0; e_ack = '0; e_val = '0;
        if (rst_n && !flush && (!m_valid || rdy[m_dst]))
            for (int k = 0; k < NODES; k++) begin
                nn = (m_ptr + k) % NODES;
                if (!any && val[nn]) begin any = 1; w = nn; end
            end
        if (any) e_ack[w] = 1'b1;
        if (m_valid) e_val[m_dst] = 1'b1;
        chk("ack", 64'(ack), 64'(e_ack));
        chk("rcv_val", 64'(rcv_val), 64'(e_val));
        chk("rcv_src", 64'(src), 64'(m_src));
        chk("rcv_tag", 64'(rtag), 64'(m_tag));
        chk("rcv_msg", rmsg, m_msg);
        chk("busy", 64'(busy), 64'(m_valid));
        chk("drop_count", 64'(drops), 64'(m_drops > 65535 ? 65535 : m_drops));
        chk("drop_count_sat", 64'(drops_s), 64'(m_drops > 7 ? 7 : m_drops));
        n_valid = m_valid; n_src = m_src; n_dst = m_dst; n_tag = m_tag; n_msg = m_msg;
        n_ptr = m_ptr; n_drops = m_drops;
        if (flush) n_valid = 0;
        else begin
            if (m_valid && rdy[m_dst]) n_valid = 0;
            if (any) begin
                n_ptr = (w + 1) % NODES;
                if (dst[w] < NODES) begin
                    n_valid = 1; n_src = w; n_dst = int'(dst[w]); n_tag = tag[w]; n_msg = msg[w];
                end else n_drops = m_drops + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_src <= 0; m_dst <= 0; m_tag <= '0; m_msg <= '0; m_ptr <= 0; m_drops <= 0;
            n_valid <= 0; n_src <= 0; n_dst <= 0; n_tag <= '0; n_msg <= '0; n_ptr <= 0; n_drops <= 0;
        end else begin
            m_valid <= n_valid; m_src <= n_src; m_dst <= n_dst; m_tag <= n_tag; m_msg <= n_msg;
            m_ptr <= n_ptr; m_drops <= n_drops;
        end
    end

    task automatic cyc;  @(posedge clk); #1; endtask
    task automatic look; @(negedge clk); #1; endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rcv_val", 64'(rcv_val), 64'd0);
        chk("rst_drops", 64'(drops), 64'd0);
        cyc; cyc;
        rst_n = 1'b1;

        // Fairness: everyone requests, all to node 0
        val = 4'b1111; rdy = 4'b0001;
        for (int n = 0; n < NODES; n++) begin
            tag[n] = 32'h10 + 32'(n); msg[n] = 64'h100 + 64'(n);
        end
        for (int k = 0; k < 5; k++) begin
            look;
            chk("fair_ack", 64'(ack), 64'(4'b0001 << (k % 4)));
            if (k > 0) chk("fair_src", 64'(src), 64'((k - 1) % 4));
            cyc;
        end
        val = '0;
        look; chk("fair_last_src", 64'(src), 64'd0); chk("fair_last_val", 64'(rcv_val), 64'b0001);
        cyc;

        // Single send node1 -> node2
        rdy = 4'b1111; val = 4'b0010; dst[1] = 32'd2; tag[1] = 32'h5; msg[1] = 64'hAB;
        look; chk("single_ack", 64'(ack), 64'b0010);
        cyc; val = '0;
        look;
        chk("single_val", 64'(rcv_val), 64'b0100); chk("single_src", 64'(src), 64'd1);
        chk("single_tag", 64'(rtag), 64'h5); chk("single_msg", rmsg, 64'hAB);
        cyc;
        look; chk("single_done", 64'(rcv_val), 64'd0);
        cyc;

        // Backpressure on node3 while node2 waits
        rdy = 4'b0111; val = 4'b0001; dst[0] = 32'd3; tag[0] = 32'h33; msg[0] = 64'h3333;
        look; chk("bp_load_ack", 64'(ack), 64'b0001);
        cyc;
        val = 4'b0100; dst[2] = 32'd1; tag[2] = 32'h22; msg[2] = 64'h2222;
        for (int k = 0; k < 5; k++) begin
            look;
            chk("bp_stall_ack", 64'(ack), 64'd0);
            chk("bp_stall_val", 64'(rcv_val), 64'b1000);
            chk("bp_stall_msg", rmsg, 64'h3333);
            cyc;
        end
        rdy = 4'b1111;
        look; chk("bp_release_ack", 64'(ack), 64'b0100); chk("bp_release_val", 64'(rcv_val), 64'b1000);
        cyc; val = '0;
        look;
        chk("bp_next_val", 64'(rcv_val), 64'b0010); chk("bp_next_src", 64'(src), 64'd2);
        chk("bp_next_msg", rmsg, 64'h2222);
        cyc;

        // Out-of-range destination
        val = 4'b0001; dst[0] = 32'd7;
        look; chk("oor_ack", 64'(ack), 64'b0001);
        cyc;
        val = 4'b0011; dst[0] = 32'd2; dst[1] = 32'd2;
        look;
        chk("oor_drops", 64'(drops), 64'd1); chk("oor_no_val", 64'(rcv_val), 64'd0);
        chk("oor_ptr_ack", 64'(ack), 64'b0010);
        cyc;
        val = 4'b0001;
        look; chk("oor_n0_ack", 64'(ack), 64'b0001);
        cyc;
        dst[0] = 32'h0000_0100;
        for (int k = 0; k < 8; k++) begin
            look; chk("oor_hi_ack", 64'(ack), 64'b0001);
            cyc;
        end
        val = '0;
        look; chk("oor_drops9", 64'(drops), 64'd9); chk("oor_sat", 64'(drops_s), 64'd7);
        cyc;

        // Flush while full, node2 waiting
        rdy = 4'b1101; val = 4'b0010; dst[1] = 32'd1; tag[1] = 32'h11; msg[1] = 64'h1111;
        look; chk("fl_load_ack", 64'(ack), 64'b0010);
        cyc;
        val = 4'b0100; dst[2] = 32'd1; tag[2] = 32'h44; msg[2] = 64'h4444; flush = 1'b1;
        look;
        chk("fl_ack", 64'(ack), 64'd0); chk("fl_val", 64'(rcv_val), 64'b0010);
        chk("fl_busy", 64'(busy), 64'd1);
        cyc; flush = 1'b0;
        look;
        chk("fl_after_busy", 64'(busy), 64'd0); chk("fl_after_val", 64'(rcv_val), 64'd0);
        chk("fl_after_ack", 64'(ack), 64'b0100);
        cyc; val = '0;
        look; chk("fl_reload_busy", 64'(busy), 64'd1); chk("fl_reload_msg", rmsg, 64'h4444);

        // Async reset with the slot full
        #1; rst_n = 1'b0; #1;
        chk("ar_busy", 64'(busy), 64'd0); chk("ar_val", 64'(rcv_val), 64'd0);
        chk("ar_src", 64'(src), 64'd0); chk("ar_tag", 64'(rtag), 64'd0);
        chk("ar_msg", rmsg, 64'd0); chk("ar_drops", 64'(drops), 64'd0);
        cyc; rst_n = 1'b1;
        val = 4'b1010; dst[1] = 32'd0; dst[3] = 32'd0;
        look; chk("ar_first_ack", 64'(ack), 64'b0010);
        cyc; val = '0;
        look; cyc; cyc;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/message_bus_arbiter.md
Name: message_bus_arbiter

Overview:
- Shares one message bus among NODES bus communication interfaces.
- Accepts send requests (val/ack protocol, dst/tag/msg) from every node and arbitrates round-robin.
- Buffers the winner in a single-entry slot and delivers it to the destination node's receive port (val/rdy protocol), presenting the sender index as the source address.
- Sits between the per-core communication interfaces and the interconnect top level.

Parameters:
- NODES, 4, number of attached nodes (2..16); node IDs are 0..NODES-1.
- ID_W, $clog2(NODES), width of internal node-index registers.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of the buffer slot.
- snd_val_i  in  NODES  per-node send request; sender holds data stable until acked.
- snd_ack_o  out  NODES  per-node one-cycle accept pulse.
- snd_dst_i  in  NODES*32  per-node destination address; node n at [32n+31:32n].
- snd_tag_i  in  NODES*32  per-node tag.
- snd_msg_i  in  NODES*64  per-node payload.
- rcv_val_o  out  NODES  per-node delivery valid, one-hot or zero.
- rcv_rdy_i  in  NODES  per-node receiver ready.
- rcv_src_o  out  32  source node index, zero-extended; shared by all receivers.
- rcv_tag_o  out  32  tag, shared.
- rcv_msg_o  out  64  payload, shared.
- busy_o  out  1  buffer slot occupied.
- drop_count_o  out  DROP_W  count of messages discarded for out-of-range destination.

Behaviour:
- State: slot_valid, slot_src, slot_dst (ID_W), slot_tag, slot_msg, rr_ptr (ID_W), drop_cnt.
  - Two-state FSM: EMPTY (slot_valid=0) and FULL (slot_valid=1).
- Reset (async): slot_valid=0, all slot fields 0, rr_ptr=0, drop_cnt=0.
  - Outputs at reset: snd_ack_o=0, rcv_val_o=0, rcv_src_o/tag/msg=0, busy_o=0, drop_count_o=0.
- Delivery:
  - rcv_val_o[slot_dst] = slot_valid; all other bits 0.
  - rcv_src_o/rcv_tag_o/rcv_msg_o are driven from the slot regardless of valid.
  - deliver = slot_valid & rcv_rdy_i[slot_dst].
- Slot free: free = !slot_valid | deliver (combinational bypass, same cycle).
- Arbitration (combinational):
  - Only when free & !flush & |snd_val_i.
  - Winner w = first n with snd_val_i[n] set, scanning rr_ptr, rr_ptr+1, ... mod NODES.
  - snd_ack_o[w]=1 in that same cycle; all other ack bits are 0.
  - snd_ack_o is all-zero whenever not free, during flush, or with no requests.
- On ack to winner w, with in-range destination (snd_dst of w < NODES, compared on all 32 bits):
  - Next cycle: slot_valid=1, slot_src=w, slot_dst=dst[ID_W-1:0], tag and msg captured.
- On ack to winner w, with out-of-range destination:
  - Message is discarded; drop_cnt increments, saturating at all-ones.
  - Slot becomes empty if deliver occurred in the same cycle, else it is unchanged (it was already empty).
- Round-robin pointer: on any ack, including a drop, rr_ptr <= (w+1) mod NODES; otherwise it holds.
- Self-send (dst == src) is legal.
- Throughput and latency:
  - One message per cycle when receivers stay ready.
  - Request to rcv_val_o latency is 1 cycle; ack is same-cycle with the grant.
- Simultaneous deliver and new grant: the slot is reloaded with the new message; no bubble.
- Flush (synchronous, priority over everything except reset):
  - slot_valid <= 0 and no ack is issued that cycle.
  - rcv_val_o still reflects the current slot during the flush cycle; a deliver in that cycle counts as delivered.
  - rr_ptr and drop_cnt are retained.
- Reset mid-transfer: the buffered message is lost; senders that were not yet acked retry naturally.
- busy_o = slot_valid.

Test Plan:
- Single send: node1 val, dst=2, tag=0x5, msg=0xAB, rcv_rdy all 1.
  - Cycle 0: ack[1]=1.
  - Cycle 1: rcv_val_o=4'b0100, src=1, tag=5, msg=0xAB.
  - Cycle 2: rcv_val_o=0.
- Fairness: all four nodes hold val continuously, all dst=0, rdy[0]=1.
  - Acks go to 0,1,2,3,0,... one per cycle.
  - rcv_src_o sequence 0,1,2,3 on consecutive cycles.
- Backpressure: slot holds msg for dst=3, rdy[3]=0 for 5 cycles, node2 requesting.
  - No ack during stall; rcv_val_o[3] stays 1 with stable data.
  - In the cycle rdy[3] rises, ack[2]=1; next cycle the slot carries node2's message.
- Out-of-range: node0 sends dst=7 (NODES=4).
  - ack[0]=1, no rcv_val_o, drop_count_o 0->1, rr_ptr=1.
  - Preload drop_cnt=0xFFFF, drop again -> stays 0xFFFF.
- Flush: slot full (dst=1, rdy[1]=0), node3 requesting, flush=1 for one cycle.
  - ack all-zero that cycle; next cycle busy_o=0, rcv_val_o=0.
  - Following cycle ack[3]=1.
- Async reset: assert rst_n=0 while slot full.
  - Immediately busy_o=0, rcv_val_o=0, rcv_src_o/tag/msg=0, drop_count_o=0.
  - After release, first grant starts search from node 0.
